// File: rtl/lab_pkg.sv
// Shared constants and helpers for the lab timebase blocks.
// Sizes prescalers and carries the board clock rate.
package lab_pkg;

    localparam int SYS_CLK_HZ = 50_000_000;

    // A divide-by-1 or -2 prescaler still needs one bit of state.
    function automatic int pre_w(input int div);
        return (div > 2) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/mod_counter_if.sv
// Control and status bundle of the modulo counter.
// master drives the controls, slave is the counter.
interface mod_counter_if #(
    parameter int WIDTH = 4
);

    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic             tick;
    logic             tc;
    logic             wrap;

    modport master (
        output en, up, load, load_val,
        input  q, tick, tc, wrap
    );

    modport slave (
        input  en, up, load, load_val,
        output q, tick, tc, wrap
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: one-cycle tick every DIV clocks.
// clr restarts the period so the next tick is DIV-1 cycles out.
module tick_gen
    import lab_pkg::*;
#(
    parameter int DIV = SYS_CLK_HZ
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    output logic tick
);

    localparam int            PW   = pre_w(DIV);
    localparam logic [PW-1:0] LAST = PW'(DIV - 1);
    localparam logic [PW-1:0] ONE  = PW'(1);

    logic [PW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + ONE;
        end
    end

    // With DIV=1 cnt sits at LAST, so reset has to mask the tick.
    assign tick = rst & (cnt == LAST);

endmodule

// File: rtl/mod_counter.sv
// Modulo-N up/down counter stepped by prescaler ticks,
// with clamped synchronous load and a registered wrap pulse.
module mod_counter
    import lab_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 16,
    parameter int DIV     = SYS_CLK_HZ
) (
    input  logic          clk,
    input  logic          rst,
    mod_counter_if.slave  bus
);

    localparam int               WP1  = WIDTH + 1;
    localparam logic [WIDTH-1:0] MAX  = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MODW = WP1'(MODULUS);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    logic             tick;
    logic             step;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] ld;
    logic             wrap_q;
    logic             wrap_d;

    tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk  (clk),
        .rst  (rst),
        .clr  (bus.load),
        .tick (tick)
    );

    assign step = tick & bus.en;

    // Out-of-range loads saturate at the top of the count range.
    assign ld = ({1'b0, bus.load_val} >= MODW) ? MAX
                                               : bus.load_val;

    always_comb begin
        q_d    = q;
        wrap_d = 1'b0;
        if (bus.load) begin
            q_d = ld;
        end else if (step && bus.up) begin
            if (q == MAX) begin
                q_d    = '0;
                wrap_d = 1'b1;
            end else begin
                q_d = q + ONE;
            end
        end else if (step) begin
            if (q == '0) begin
                q_d    = MAX;
                wrap_d = 1'b1;
            end else begin
                q_d = q - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q      <= '0;
            wrap_q <= 1'b0;
        end else begin
            q      <= q_d;
            wrap_q <= wrap_d;
        end
    end

    assign bus.q    = q;
    assign bus.tick = tick;
    assign bus.wrap = wrap_q;
    assign bus.tc   = bus.up ? (q == MAX) : (q == '0);

endmodule

// File: tb/tb_mod_counter.sv
// Bench for mod_counter: DIV=4 and DIV=1 builds, MODULUS=10,
// checked every cycle against an arithmetic model plus literals.
module tb_mod_counter;

    localparam int M = 10;

    typedef struct packed {
        int   q;
        int   cnt;
        logic wrap;
    } ms_t;

    logic clk;
    logic rst;

    int nerr;
    int nchk;
    int wraps4;
    int ticks4;
    int tcs4;
    int wraps1;

    ms_t ms4;
    ms_t ms1;

    mod_counter_if #(.WIDTH(4)) b4 ();
    mod_counter_if #(.WIDTH(4)) b1 ();

    mod_counter #(
        .WIDTH   (4),
        .MODULUS (M),
        .DIV     (4)
    ) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (b4.slave)
    );

    mod_counter #(
        .WIDTH   (4),
        .MODULUS (M),
        .DIV     (1)
    ) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int got,
                       input int exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%0d exp=%0d t=%0t",
                     nm, got, exp, $time);
        end
    endtask

    // Cycles since reset/load fix the phase; q moves modulo M.
    function automatic ms_t nx(input ms_t s, input int d,
                               input logic en, input logic up,
                               input logic load,
                               input logic [3:0] lv);
        ms_t n;
        bit  tk;
        n      = s;
        tk     = (s.cnt % d) == d - 1;
        n.wrap = 1'b0;
        n.cnt  = s.cnt + 1;
        if (load) begin
            n.q   = (int'(lv) >= M) ? M - 1 : int'(lv);
            n.cnt = 0;
        end else if (tk && en) begin
            if (up) begin
                n.wrap = (s.q + 1 == M);
                n.q    = (s.q + 1) % M;
            end else begin
                n.wrap = (s.q == 0);
                n.q    = (s.q + M - 1) % M;
            end
        end
        return n;
    endfunction

    function automatic int mtick(input ms_t s, input int d);
        return (rst && (s.cnt % d) == d - 1) ? 1 : 0;
    endfunction

    function automatic int mtc(input int q, input logic up);
        return (up ? (q == M - 1) : (q == 0)) ? 1 : 0;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms4 <= '0;
            ms1 <= '0;
        end else begin
            ms4 <= nx(ms4, 4, b4.en, b4.up, b4.load,
                      b4.load_val);
            ms1 <= nx(ms1, 1, b1.en, b1.up, b1.load,
                      b1.load_val);
        end
    end

    always @(negedge clk) begin
        chk("q4", int'(b4.q), ms4.q);
        chk("tick4", int'(b4.tick), mtick(ms4, 4));
        chk("tc4", int'(b4.tc), mtc(ms4.q, b4.up));
        chk("wrap4", int'(b4.wrap), int'(ms4.wrap));
        chk("q1", int'(b1.q), ms1.q);
        chk("tick1", int'(b1.tick), mtick(ms1, 1));
        chk("tc1", int'(b1.tc), mtc(ms1.q, b1.up));
        chk("wrap1", int'(b1.wrap), int'(ms1.wrap));
        wraps4 += int'(b4.wrap);
        ticks4 += int'(b4.tick);
        tcs4   += int'(b4.tc);
        wraps1 += int'(b1.wrap);
    end

    task automatic go(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    initial begin
        nerr = 0;
        nchk = 0;
        wraps4 = 0;
        ticks4 = 0;
        tcs4 = 0;
        wraps1 = 0;
        rst = 1'b0;
        b4.en = 1'b0;
        b4.up = 1'b1;
        b4.load = 1'b0;
        b4.load_val = '0;
        b1.en = 1'b0;
        b1.up = 1'b1;
        b1.load = 1'b0;
        b1.load_val = '0;

        go(2);
        chk("rst_q", int'(b4.q), 0);
        chk("rst_wrap", int'(b4.wrap), 0);
        chk("rst_tick", int'(b4.tick), 0);
        chk("rst_tc_up", int'(b4.tc), 0);
        chk("rst_tick1", int'(b1.tick), 0);

        rst = 1'b1;
        b4.en = 1'b1;
        wraps4 = 0;
        tcs4 = 0;
        go(44);
        chk("up44_q", int'(b4.q), 1);
        chk("up44_wraps", wraps4, 1);
        chk("up44_tcs", tcs4, 4);

        rst = 1'b0;
        b4.up = 1'b0;
        #1;
        chk("dn_tc0", int'(b4.tc), 1);
        go(1);
        rst = 1'b1;
        go(4);
        chk("dn_q9", int'(b4.q), 9);
        chk("dn_wrap", int'(b4.wrap), 1);
        go(4);
        chk("dn_q8", int'(b4.q), 8);
        chk("dn_wrap0", int'(b4.wrap), 0);

        go(1);
        b4.load = 1'b1;
        b4.load_val = 4'd7;
        go(1);
        b4.load = 1'b0;
        chk("ld7_q", int'(b4.q), 7);
        go(2);
        chk("ld7_notick", int'(b4.tick), 0);
        go(1);
        chk("ld7_tick", int'(b4.tick), 1);
        go(1);
        chk("ld7_step", int'(b4.q), 6);
        b4.load = 1'b1;
        b4.load_val = 4'd13;
        go(1);
        b4.load = 1'b0;
        chk("ld13_clamp", int'(b4.q), 9);

        b4.up = 1'b1;
        go(3);
        chk("lt_tick", int'(b4.tick), 1);
        chk("lt_tc", int'(b4.tc), 1);
        b4.load = 1'b1;
        b4.load_val = 4'd4;
        go(1);
        b4.load = 1'b0;
        chk("lt_q", int'(b4.q), 4);
        chk("lt_wrap", int'(b4.wrap), 0);

        b4.en = 1'b0;
        ticks4 = 0;
        go(12);
        chk("en0_q", int'(b4.q), 4);
        chk("en0_ticks", ticks4, 3);
        b4.en = 1'b1;
        go(4);
        chk("en1_q", int'(b4.q), 5);

        #1;
        rst = 1'b0;
        #1;
        chk("arst_q", int'(b4.q), 0);
        chk("arst_wrap", int'(b4.wrap), 0);
        chk("arst_tick", int'(b4.tick), 0);
        go(1);
        rst = 1'b1;
        go(2);
        chk("rel_notick", int'(b4.tick), 0);
        go(1);
        chk("rel_tick", int'(b4.tick), 1);

        b1.en = 1'b1;
        wraps1 = 0;
        go(9);
        chk("d1_q9", int'(b1.q), 9);
        go(1);
        chk("d1_q0", int'(b1.q), 0);
        chk("d1_wrap", int'(b1.wrap), 1);
        go(1);
        chk("d1_q1", int'(b1.q), 1);
        chk("d1_wraps", wraps1, 1);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
